// File: rtl/itrx_amba2_ahb_pkg.sv
// Shared AMBA2 AHB transfer encodings plus lane-decode helpers used by AHB slaves.
package itrx_amba2_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } te_htrans;

    typedef enum logic {
        HWRITE_READ  = 1'b0,
        HWRITE_WRITE = 1'b1
    } te_hwrite;

    typedef enum logic [2:0] {
        HSIZE_BYTE     = 3'd0,
        HSIZE_HALFWORD = 3'd1,
        HSIZE_WORD     = 3'd2,
        HSIZE_DBLWORD  = 3'd3,
        HSIZE_4WLINE   = 3'd4,
        HSIZE_8WLINE   = 3'd5,
        HSIZE_16WLINE  = 3'd6,
        HSIZE_32WLINE  = 3'd7
    } te_hsize;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } te_hresp;

    // Little-endian byte-lane enables; lane offset wraps within the data bus width.
    function automatic logic [7:0] f_ahb_be(input logic [2:0] addr_lsbs, input te_hsize hsize,
                                            input int nbytes);
        logic [7:0] mask;
        logic [7:0] lanes;
        logic [2:0] ofs;
        case (hsize)
            HSIZE_BYTE:     mask = 8'h01;
            HSIZE_HALFWORD: mask = 8'h03;
            HSIZE_WORD:     mask = 8'h0F;
            HSIZE_DBLWORD:  mask = 8'hFF;
            default:        mask = 8'h00;
        endcase
        ofs   = addr_lsbs & 3'(nbytes - 1);
        lanes = 8'hFF >> (4'd8 - 4'(nbytes));
        return (mask << ofs) & lanes;
    endfunction

    function automatic logic f_ahb_misaligned(input logic [2:0] addr_lsbs, input te_hsize hsize);
        logic mis;
        case (hsize)
            HSIZE_BYTE:     mis = 1'b0;
            HSIZE_HALFWORD: mis = addr_lsbs[0];
            HSIZE_WORD:     mis = |addr_lsbs[1:0];
            HSIZE_DBLWORD:  mis = |addr_lsbs;
            default:        mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/itrx_amba2_ahb_slv_mem.sv
// AHB slave terminating transfers onto a req/ack memory port: posted writes with one
// write buffer, stalled reads, and the two-cycle ERROR response for illegal transfers.
module itrx_amba2_ahb_slv_mem
    import itrx_amba2_ahb_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 12,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic                        hsel,
    input  logic [AW-1:0]               haddr,
    input  te_htrans                    htrans,
    input  te_hwrite                    hwrite,
    input  te_hsize                     hsize,
    input  logic [DW-1:0]               hwdata,
    input  logic                        hreadyin,
    output logic                        hreadyout,
    output te_hresp                     hresp,
    output logic [DW-1:0]               hrdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [AW-$clog2(DW/8)-1:0]  mem_addr,
    output logic [DW/8-1:0]             mem_be,
    output logic [DW-1:0]               mem_wdata,
    input  logic                        mem_ack,
    input  logic [DW-1:0]               mem_rdata
);

    localparam int NB  = DW / 8;
    localparam int BW  = $clog2(NB);
    localparam int WAW = AW - BW;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WDATA, ST_WMEM, ST_RD, ST_RDONE, ST_ERR1, ST_ERR2
    } te_ahb_slv_mem_st;

    te_ahb_slv_mem_st state_r;

    logic           pend_vld_r, pend_wr_r, pend_err_r;
    logic [WAW-1:0] pend_addr_r;
    logic [NB-1:0]  pend_be_r;

    logic           accept_s, acc_wr_s, acc_err_s;
    logic [WAW-1:0] acc_addr_s;
    logic [NB-1:0]  acc_be_s;
    logic           disp_now_s, disp_vld_s, disp_wr_s, disp_err_s;
    logic [WAW-1:0] disp_addr_s;
    logic [NB-1:0]  disp_be_s;

    // Decode of the address phase currently on the bus.
    always_comb begin
        accept_s   = hsel & hreadyin & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
        acc_wr_s   = (hwrite == HWRITE_WRITE);
        acc_addr_s = haddr[AW-1:BW];
        acc_be_s   = NB'(f_ahb_be(haddr[2:0], hsize, NB));
        acc_err_s  = (3'(hsize) > 3'(BW)) | f_ahb_misaligned(haddr[2:0], hsize)
                   | (32'(acc_addr_s) >= 32'(MEM_DEPTH));
    end

    // Next transfer to start: a buffered one always goes before a newly accepted one.
    always_comb begin
        if (pend_vld_r) begin
            disp_vld_s  = 1'b1;
            disp_wr_s   = pend_wr_r;
            disp_err_s  = pend_err_r;
            disp_addr_s = pend_addr_r;
            disp_be_s   = pend_be_r;
        end else begin
            disp_vld_s  = accept_s;
            disp_wr_s   = acc_wr_s;
            disp_err_s  = acc_err_s;
            disp_addr_s = acc_addr_s;
            disp_be_s   = acc_be_s;
        end
    end

    // States in which the FSM is free to start the next transfer at this edge.
    always_comb begin
        disp_now_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RDONE, ST_ERR2: disp_now_s = 1'b1;
            ST_WMEM:                    disp_now_s = mem_ack;
            default:                    disp_now_s = 1'b0;
        endcase
    end

    // Transfer FSM with registered AHB and memory-port outputs.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= ST_IDLE;
            pend_vld_r  <= 1'b0;
            pend_wr_r   <= 1'b0;
            pend_err_r  <= 1'b0;
            pend_addr_r <= '0;
            pend_be_r   <= '0;
            hreadyout   <= 1'b1;
            hresp       <= HRESP_OKAY;
            hrdata      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else if (disp_now_s) begin
            pend_vld_r <= 1'b0;
            mem_we     <= 1'b0;
            if (!disp_vld_s) begin
                state_r   <= ST_IDLE;
                hreadyout <= 1'b1;
                hresp     <= HRESP_OKAY;
                mem_req   <= 1'b0;
            end else if (disp_err_s) begin
                state_r   <= ST_ERR1;
                hreadyout <= 1'b0;
                hresp     <= HRESP_ERROR;
                mem_req   <= 1'b0;
            end else begin
                mem_addr  <= disp_addr_s;
                mem_be    <= disp_be_s;
                hresp     <= HRESP_OKAY;
                // Writes get a zero-wait data phase; reads stall and request at once.
                state_r   <= disp_wr_s ? ST_WDATA : ST_RD;
                hreadyout <= disp_wr_s;
                mem_req   <= ~disp_wr_s;
            end
        end else begin
            case (state_r)
                ST_WDATA: begin
                    mem_wdata <= hwdata;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    state_r   <= ST_WMEM;
                    hreadyout <= ~accept_s;
                    if (accept_s) begin
                        pend_vld_r  <= 1'b1;
                        pend_wr_r   <= acc_wr_s;
                        pend_err_r  <= acc_err_s;
                        pend_addr_r <= acc_addr_s;
                        pend_be_r   <= acc_be_s;
                    end
                end
                ST_WMEM: begin
                    if (accept_s) begin
                        pend_vld_r  <= 1'b1;
                        pend_wr_r   <= acc_wr_s;
                        pend_err_r  <= acc_err_s;
                        pend_addr_r <= acc_addr_s;
                        pend_be_r   <= acc_be_s;
                        hreadyout   <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        hrdata    <= mem_rdata;
                        mem_req   <= 1'b0;
                        hreadyout <= 1'b1;
                        state_r   <= ST_RDONE;
                    end
                end
                ST_ERR1: begin
                    hreadyout <= 1'b1;
                    state_r   <= ST_ERR2;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itrx_amba2_ahb_slv_mem.sv
// Directed self-checking bench for itrx_amba2_ahb_slv_mem (DW=32, AW=13, MEM_DEPTH=1024).
module tb_itrx_amba2_ahb_slv_mem;
    import itrx_amba2_ahb_pkg::*;

    logic        hclk, hresetn, hsel, hreadyin, hreadyout;
    logic [12:0] haddr;
    te_htrans    htrans;
    te_hwrite    hwrite;
    te_hsize     hsize;
    te_hresp     hresp;
    logic [31:0] hwdata, hrdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [10:0] mem_addr;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    assign hreadyin = hreadyout;

    itrx_amba2_ahb_slv_mem #(.DW(32), .AW(13), .MEM_DEPTH(1024)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = HWRITE_READ;
        hsize  = HSIZE_WORD;
        haddr  = 13'h0;
    endtask

    task automatic addr_ph(input logic [12:0] a, input te_htrans tr, input te_hwrite wr,
                           input te_hsize sz);
        hsel   = 1'b1;
        haddr  = a;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
    endtask

    task automatic err_case(input string tag, input logic [12:0] a, input te_hsize sz);
        addr_ph(a, HTRANS_NONSEQ, HWRITE_READ, sz);
        cyc();
        bus_idle();
        chk({tag, "_err1_resp"}, 64'(hresp), 64'(HRESP_ERROR));
        chk({tag, "_err1_rdy"}, 64'(hreadyout), 64'd0);
        chk({tag, "_err1_req"}, 64'(mem_req), 64'd0);
        cyc();
        chk({tag, "_err2_resp"}, 64'(hresp), 64'(HRESP_ERROR));
        chk({tag, "_err2_rdy"}, 64'(hreadyout), 64'd1);
        chk({tag, "_err2_req"}, 64'(mem_req), 64'd0);
        cyc();
        chk({tag, "_after_resp"}, 64'(hresp), 64'(HRESP_OKAY));
    endtask

    task automatic noop_case(input string tag, input logic sel, input te_htrans tr);
        addr_ph(13'h010, tr, HWRITE_WRITE, HSIZE_WORD);
        hsel = sel;
        cyc();
        chk({tag, "_rdy"}, 64'(hreadyout), 64'd1);
        chk({tag, "_resp"}, 64'(hresp), 64'(HRESP_OKAY));
        chk({tag, "_req"}, 64'(mem_req), 64'd0);
        bus_idle();
        cyc();
        chk({tag, "_req2"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        int a_idx, d_idx, hs_cnt;
        logic rdy;
        hresetn   = 1'b0;
        hwdata    = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        bus_idle();
        cyc();
        cyc();
        chk("rst_rdy", 64'(hreadyout), 64'd1);
        chk("rst_resp", 64'(hresp), 64'(HRESP_OKAY));
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        hresetn = 1'b1;
        cyc();

        // Single WORD read at 0x010, ack one cycle after request.
        addr_ph(13'h010, HTRANS_NONSEQ, HWRITE_READ, HSIZE_WORD);
        cyc();
        bus_idle();
        chk("rd_req", 64'(mem_req), 64'd1);
        chk("rd_we", 64'(mem_we), 64'd0);
        chk("rd_addr", 64'(mem_addr), 64'h004);
        chk("rd_be", 64'(mem_be), 64'hF);
        chk("rd_wait1", 64'(hreadyout), 64'd0);
        cyc();
        chk("rd_wait2", 64'(hreadyout), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_ack = 1'b0;
        chk("rd_done_rdy", 64'(hreadyout), 64'd1);
        chk("rd_done_data", 64'(hrdata), 64'hDEADBEEF);
        chk("rd_done_resp", 64'(hresp), 64'(HRESP_OKAY));
        chk("rd_done_req", 64'(mem_req), 64'd0);
        cyc();
        chk("rd_hold", 64'(hrdata), 64'hDEADBEEF);

        // Reset asserted while a read is outstanding.
        addr_ph(13'h020, HTRANS_NONSEQ, HWRITE_READ, HSIZE_WORD);
        cyc();
        bus_idle();
        chk("midrd_req", 64'(mem_req), 64'd1);
        #2 hresetn = 1'b0;
        #1;
        chk("arst_req", 64'(mem_req), 64'd0);
        chk("arst_rdy", 64'(hreadyout), 64'd1);
        chk("arst_hrdata", 64'(hrdata), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_be", 64'(mem_be), 64'd0);
        cyc();
        hresetn = 1'b1;
        cyc();
        chk("rel_rdy", 64'(hreadyout), 64'd1);
        chk("rel_resp", 64'(hresp), 64'(HRESP_OKAY));
        chk("rel_req", 64'(mem_req), 64'd0);

        // BYTE write at 0x003 followed directly by WORD read at 0x000; write ack delayed.
        addr_ph(13'h003, HTRANS_NONSEQ, HWRITE_WRITE, HSIZE_BYTE);
        cyc();
        chk("wr_zero_wait", 64'(hreadyout), 64'd1);
        hwdata = 32'hAB000000;
        addr_ph(13'h000, HTRANS_NONSEQ, HWRITE_READ, HSIZE_WORD);
        cyc();
        bus_idle();
        hwdata = 32'h0;
        chk("wr_we", 64'(mem_we), 64'd1);
        chk("wr_be", 64'(mem_be), 64'h8);
        chk("wr_wdata", 64'(mem_wdata), 64'hAB000000);
        chk("wr_addr", 64'(mem_addr), 64'h000);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rd_held", 64'(hreadyout), 64'd0);
            chk("wr_req_held", 64'(mem_req), 64'd1);
            cyc();
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("wr2rd_req", 64'(mem_req), 64'd1);
        chk("wr2rd_we", 64'(mem_we), 64'd0);
        chk("wr2rd_be", 64'(mem_be), 64'hF);
        chk("wr2rd_rdy", 64'(hreadyout), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11223344;
        cyc();
        mem_ack = 1'b0;
        chk("wr2rd_data", 64'(hrdata), 64'h11223344);
        chk("wr2rd_done", 64'(hreadyout), 64'd1);
        cyc();

        // Illegal transfers.
        err_case("mis_half", 13'h001, HSIZE_HALFWORD);
        err_case("dbl_size", 13'h000, HSIZE_DBLWORD);
        err_case("oor_addr", 13'h1000, HSIZE_WORD);

        // Transfers that must not be accepted.
        noop_case("noop_idle", 1'b1, HTRANS_IDLE);
        noop_case("noop_busy", 1'b1, HTRANS_BUSY);
        noop_case("noop_unsel", 1'b0, HTRANS_NONSEQ);

        // INCR4 write burst at 0x20..0x2C with mem_ack held high; simple AHB master model.
        mem_ack = 1'b1;
        a_idx   = 0;
        d_idx   = 4;
        hs_cnt  = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_idx < 4)
                addr_ph(13'h020 + 13'(4 * a_idx), (a_idx == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                        HWRITE_WRITE, HSIZE_WORD);
            else
                bus_idle();
            hwdata = (d_idx < 4) ? 32'h100 + 32'(d_idx) : 32'h0;
            rdy = hreadyout;
            if (c == 1)
                chk("burst_first_zero_wait", 64'(hreadyout), 64'd1);
            if (mem_req && mem_ack) begin
                if (hs_cnt < 4) begin
                    chk("burst_addr", 64'(mem_addr), 64'(11'h008 + 11'(hs_cnt)));
                    chk("burst_wdata", 64'(mem_wdata), 64'(32'h100 + 32'(hs_cnt)));
                    chk("burst_we", 64'(mem_we), 64'd1);
                end
                hs_cnt++;
            end
            cyc();
            if (rdy) begin
                d_idx = a_idx;
                a_idx = (a_idx < 4) ? a_idx + 1 : 4;
            end
        end
        mem_ack = 1'b0;
        chk("burst_handshakes", 64'(hs_cnt), 64'd4);
        chk("burst_end_req", 64'(mem_req), 64'd0);
        chk("burst_end_rdy", 64'(hreadyout), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
